task_scheduler: RTL and testbench
=================================

# task_scheduler

Time-slice scheduler that sits directly downstream of the ready list. On a slice expiry, a yield, or while idle, it scans priority levels from highest to lowest and requests the next task at each level through the ready list's get handshake. It registers the first valid task ID as the running task and pulses a context-switch strobe to the CPU's context-save/restore logic when the running task changes.

## Interface
- NPRI, 5: number of priority levels scanned, highest index first; max 8.
- SLICE, 16: ticks per time slice; range 1..255.
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- tick_i  in  1  one-cycle timer tick pulse.
- yield_i  in  1  one-cycle pulse; the running task gives up the rest of its slice.
- sched_en_i  in  1  enables scheduling. When low, no new scan starts; a scan already in progress completes.
- rl_get_o  out  1  get request to the ready list; one-cycle pulse.
- rl_priority_o  out  3  priority level being queried; held stable from the get pulse until the response.
- rl_tid_i  in  5  task ID returned by the ready list; 5'h1F means the level is empty.
- rl_done_i  in  1  ready-list done/idle flag.
- cur_tid_o  out  4  ID of the running task.
- cur_pri_o  out  3  priority of the running task.
- cur_valid_o  out  1  a running task is selected.
- switch_o  out  1  one-cycle pulse when cur_tid_o/cur_pri_o change to a different task.
- idle_o  out  1  the last scan found no ready task at any level.

## Operation
- States: IDLE, REQ, WAIT0, WAITD, NEXT.
- Slice counter is 8 bits.
  - Reset to 0 on every dispatch.
  - Increments on tick_i in every state and saturates at SLICE.
- Scan trigger, evaluated only in IDLE with sched_en_i=1. Any of:
  - yield_i.
  - slice counter == SLICE.
  - cur_valid_o=0 and tick_i.
- The trigger loads scan level p = NPRI-1, then goes to REQ.
- REQ:
  - If rl_done_i=0 (ready list busy with an insert/remove), stay in REQ with rl_get_o low.
  - Otherwise pulse rl_get_o with rl_priority_o=p and go to WAIT0.
- WAIT0 (cycle after the get pulse):
  - rl_done_i=1 and rl_tid_i=5'h1F: level empty, go to NEXT.
  - rl_done_i=0: go to WAITD.
- WAITD: wait for rl_done_i=1, then dispatch rl_tid_i[3:0] at priority p and go to IDLE.
- NEXT:
  - If p==0: set cur_valid_o=0 and idle_o=1, go to IDLE.
  - Otherwise decrement p and go to REQ.
- Dispatch:
  - Updates cur_tid_o and cur_pri_o.
  - Sets cur_valid_o=1 and idle_o=0.
  - Clears the slice counter.
  - Pulses switch_o only if the previous cur_valid_o=0, or the tid or priority differ.
  - Re-selecting the same task (the only task at its level) does not pulse switch_o.
- yield_i outside IDLE is ignored. A slice expiry during a scan is serviced on return to IDLE, because the counter stays saturated.
- Priority index beyond NPRI-1 is never issued.

## Timing
- Reset (asynchronous, rst_ni low): all of the following take effect immediately, regardless of state.
  - state=IDLE.
  - rl_get_o=0, rl_priority_o=0.
  - cur_tid_o=0, cur_pri_o=0, cur_valid_o=0.
  - switch_o=0, idle_o=0.
  - slice counter=0.
  - A mid-scan reset abandons the scan; the ready list sees no further get.
- rl_get_o is high for exactly one cycle per queried level. Its minimum spacing is 3 cycles (REQ, WAIT0, NEXT).
- Best-case latency, trigger in IDLE to dispatch with the highest level non-empty and ready list idle:
  - get at cycle +1.
  - WAIT0 sees rl_done_i=0 at cycle +2.
  - rl_done_i=1 at cycle +3.
  - cur_tid_o/switch_o valid at cycle +4.
- Each empty level adds 3 cycles.
- All outputs are registered. switch_o asserts in the same cycle cur_tid_o takes its new value.

## Test plan
- Reset release, sched_en_i=1, ready list entirely empty, one tick_i:
  - five gets are issued, priorities 4,3,2,1,0;
  - then idle_o=1, cur_valid_o=0, no switch_o.
- Task 7 at priority 2 only, then tick_i:
  - gets at priorities 4,3,2;
  - cur_tid_o=7, cur_pri_o=2, cur_valid_o=1;
  - switch_o pulses once.
- Tasks 3 and 5 both at priority 4, SLICE=4:
  - after each 4 ticks the running task alternates 3→5→3;
  - switch_o pulses on each change.
- Single task 9 at priority 1, yield_i:
  - rescan re-selects 9;
  - switch_o stays 0;
  - slice counter returns to 0.
- Hold rl_done_i=0 for 10 cycles while the scheduler is in REQ:
  - rl_get_o stays 0 throughout;
  - the get is issued in the first cycle rl_done_i=1 is sampled.
- Assert rst_ni low during WAITD:
  - all outputs return to reset values without waiting for a clock edge;
  - after release, no get is issued until the next trigger.

Source files
------------

// File: rtl/task_scheduler.sv
// Time-slice scheduler: scans priority levels top-down through the ready list's
// get handshake, registers the first ready task and flags context switches.
module task_scheduler #(
  parameter int NPRI  = 5,
  parameter int SLICE = 16
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       yield_i,
  input  logic       sched_en_i,
  output logic       rl_get_o,
  output logic [2:0] rl_priority_o,
  input  logic [4:0] rl_tid_i,
  input  logic       rl_done_i,
  output logic [3:0] cur_tid_o,
  output logic [2:0] cur_pri_o,
  output logic       cur_valid_o,
  output logic       switch_o,
  output logic       idle_o
);
  localparam logic [2:0] TOP_PRI   = 3'(NPRI - 1);
  localparam logic [7:0] SLICE_MAX = 8'(SLICE);
  localparam logic [4:0] EMPTY_TID = 5'h1F;

  typedef enum logic [2:0] {IDLE, REQ, WAIT0, WAITD, NEXT} state_t;

  state_t     state_reg, state_next;
  logic [7:0] slice_reg, slice_next;
  logic       get_next;
  logic [2:0] pri_next;
  logic [3:0] tid_next;
  logic [2:0] cur_pri_next;
  logic       valid_next, switch_next, idle_next;
  logic       trigger, level_empty, dispatch, scan_end;

  assign trigger     = sched_en_i & (yield_i | (slice_reg == SLICE_MAX) | (~cur_valid_o & tick_i));
  assign level_empty = rl_done_i & (rl_tid_i == EMPTY_TID);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg     <= IDLE;
      slice_reg     <= 8'd0;
      rl_get_o      <= 1'b0;
      rl_priority_o <= 3'd0;
      cur_tid_o     <= 4'd0;
      cur_pri_o     <= 3'd0;
      cur_valid_o   <= 1'b0;
      switch_o      <= 1'b0;
      idle_o        <= 1'b0;
    end else begin
      state_reg     <= state_next;
      slice_reg     <= slice_next;
      rl_get_o      <= get_next;
      rl_priority_o <= pri_next;
      cur_tid_o     <= tid_next;
      cur_pri_o     <= cur_pri_next;
      cur_valid_o   <= valid_next;
      switch_o      <= switch_next;
      idle_o        <= idle_next;
    end
  end

  // A get is only registered while the ready list reports idle, so REQ leaves
  // exactly in the cycle its get pulse is on the bus.
  always_comb begin
    state_next = state_reg;
    dispatch   = 1'b0;
    scan_end   = 1'b0;
    case (state_reg)
      IDLE: if (trigger) state_next = REQ;
      REQ:  if (rl_get_o) state_next = WAIT0;
      WAIT0, WAITD: begin
        if (level_empty) begin
          state_next = NEXT;
        end else if (rl_done_i) begin
          dispatch   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = WAITD;
        end
      end
      NEXT: begin
        if (rl_priority_o == 3'd0) begin
          scan_end   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = REQ;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    get_next     = (state_next == REQ) & rl_done_i;
    pri_next     = rl_priority_o;
    tid_next     = cur_tid_o;
    cur_pri_next = cur_pri_o;
    valid_next   = cur_valid_o;
    switch_next  = 1'b0;
    idle_next    = idle_o;
    slice_next   = slice_reg;
    if (state_reg == IDLE && trigger) begin
      pri_next = TOP_PRI;
    end else if (state_reg == NEXT && !scan_end) begin
      pri_next = rl_priority_o - 3'd1;
    end
    if (dispatch) begin
      tid_next     = rl_tid_i[3:0];
      cur_pri_next = rl_priority_o;
      valid_next   = 1'b1;
      idle_next    = 1'b0;
      switch_next  = ~cur_valid_o | (rl_tid_i[3:0] != cur_tid_o) | (rl_priority_o != cur_pri_o);
    end else if (scan_end) begin
      valid_next = 1'b0;
      idle_next  = 1'b1;
    end
    // Saturation keeps an expired slice pending until the scheduler is back in IDLE.
    if (dispatch) begin
      slice_next = 8'd0;
    end else if (tick_i && slice_reg != SLICE_MAX) begin
      slice_next = slice_reg + 8'd1;
    end
  end
endmodule

// File: tb/tb_task_scheduler.sv
// Bench for task_scheduler: round-robin ready-list model per level plus an
// abstract scheduler model (top-down first non-empty level, slice counting).
module tb_task_scheduler;
  localparam int NPRI  = 5;
  localparam int SLICE = 4;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b1;
  logic       tick_i = 1'b0;
  logic       yield_i = 1'b0;
  logic       sched_en_i = 1'b0;
  logic       rl_get_o;
  logic [2:0] rl_priority_o;
  logic [4:0] rl_tid_i;
  logic       rl_done_i;
  logic [3:0] cur_tid_o;
  logic [2:0] cur_pri_o;
  logic       cur_valid_o;
  logic       switch_o;
  logic       idle_o;

  int checks = 0;
  int errors = 0;

  int lvl_cnt  [NPRI];
  int lvl_head [NPRI];
  int lvl_task [NPRI][4];

  logic       resp_done = 1'b1;
  logic [4:0] resp_tid  = 5'h1F;
  logic       hold_busy = 1'b0;
  int resp_wait = 0, pend_tid = 0, force_lat = 0, last_lat = 0, gp = 0;
  int ncyc = 0, sw_count = 0, sw_cyc = 0, first_get_cyc = 0;
  int get_log[$];

  int exp_tid = 0, exp_pri = 0, slice_model = 0;
  bit exp_valid = 1'b0, exp_idle = 1'b0;

  assign rl_done_i = resp_done & ~hold_busy;
  assign rl_tid_i  = resp_tid;

  always #5 clk_i = ~clk_i;

  task_scheduler #(.NPRI(NPRI), .SLICE(SLICE)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .tick_i       (tick_i),
    .yield_i      (yield_i),
    .sched_en_i   (sched_en_i),
    .rl_get_o     (rl_get_o),
    .rl_priority_o(rl_priority_o),
    .rl_tid_i     (rl_tid_i),
    .rl_done_i    (rl_done_i),
    .cur_tid_o    (cur_tid_o),
    .cur_pri_o    (cur_pri_o),
    .cur_valid_o  (cur_valid_o),
    .switch_o     (switch_o),
    .idle_o       (idle_o)
  );

  // Ready-list responder and event monitor, active mid-cycle.
  always @(negedge clk_i) begin
    ncyc++;
    if (switch_o) begin
      sw_count++;
      sw_cyc = ncyc;
    end
    if (resp_wait > 0) begin
      resp_wait--;
      if (resp_wait == 0) begin
        resp_done = 1'b1;
        resp_tid  = 5'(pend_tid);
      end
    end
    if (rl_get_o) begin
      gp = int'(rl_priority_o);
      if (get_log.size() == 0) first_get_cyc = ncyc;
      get_log.push_back(gp);
      if (gp >= NPRI || lvl_cnt[gp] == 0) begin
        resp_tid  = 5'h1F;
        resp_done = 1'b1;
      end else begin
        pend_tid     = lvl_task[gp][lvl_head[gp]];
        lvl_head[gp] = (lvl_head[gp] + 1) % lvl_cnt[gp];
        resp_done    = 1'b0;
        last_lat     = (force_lat > 0) ? force_lat : int'($urandom_range(2, 4));
        resp_wait    = last_lat;
      end
    end
  end

  task automatic check_eq(input string tag, input int obs, input int exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic clear_list();
    for (int l = 0; l < NPRI; l++) begin
      lvl_cnt[l]  = 0;
      lvl_head[l] = 0;
    end
  endtask

  task automatic put_task(input int l, input int t);
    lvl_task[l][lvl_cnt[l]] = t;
    lvl_cnt[l]++;
  endtask

  task automatic check_outputs_reset(input string tag);
    check_eq({tag, "_get"}, int'(rl_get_o), 0);
    check_eq({tag, "_rlpri"}, int'(rl_priority_o), 0);
    check_eq({tag, "_tid"}, int'(cur_tid_o), 0);
    check_eq({tag, "_pri"}, int'(cur_pri_o), 0);
    check_eq({tag, "_valid"}, int'(cur_valid_o), 0);
    check_eq({tag, "_switch"}, int'(switch_o), 0);
    check_eq({tag, "_idle"}, int'(idle_o), 0);
  endtask

  // mode: 0 tick, 1 yield, 2 slice expiry, 3 yield with ready list held busy
  task automatic run_scan(input int mode);
    int f, ngets, t0, sw0, tid_e, guard;
    bit sw_e;
    f = -1;
    for (int l = NPRI - 1; l >= 0; l--) if (f < 0 && lvl_cnt[l] > 0) f = l;
    ngets = (f < 0) ? NPRI : NPRI - f;
    tid_e = (f < 0) ? 0 : lvl_task[f][lvl_head[f]];
    get_log.delete();
    sw0 = sw_count;
    t0  = ncyc;
    case (mode)
      0: begin
        tick_i = 1'b1; t0 = ncyc; step(); tick_i = 1'b0;
        if (slice_model < SLICE) slice_model++;
      end
      1: begin
        yield_i = 1'b1; t0 = ncyc; step(); yield_i = 1'b0;
      end
      2: begin
        while (slice_model < SLICE) begin
          tick_i = 1'b1; t0 = ncyc + 1; step();
          slice_model++;
        end
        tick_i = 1'b0;
      end
      default: begin
        hold_busy = 1'b1;
        yield_i = 1'b1; step(); yield_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
          check_eq("busy_get_low", int'(rl_get_o), 0);
          step();
        end
        hold_busy = 1'b0;
        step();
        check_eq("busy_release_get", int'(rl_get_o), 1);
      end
    endcase
    guard = 0;
    while (!(get_log.size() >= ngets && resp_wait == 0) && guard < 100) begin
      step();
      guard++;
    end
    if (guard >= 100) check_eq("scan_timeout", get_log.size(), ngets);
    repeat (4) step();

    check_eq("num_gets", get_log.size(), ngets);
    for (int i = 0; i < get_log.size() && i < ngets; i++) check_eq("get_pri", get_log[i], NPRI - 1 - i);
    if (mode != 3) check_eq("get_latency", first_get_cyc - t0, 1);

    if (f >= 0) begin
      sw_e = !exp_valid || (tid_e != exp_tid) || (f != exp_pri);
      exp_valid = 1'b1; exp_tid = tid_e; exp_pri = f; exp_idle = 1'b0; slice_model = 0;
    end else begin
      sw_e = 1'b0;
      exp_valid = 1'b0; exp_idle = 1'b1;
    end
    check_eq("switch_count", sw_count - sw0, int'(sw_e));
    if (sw_e) check_eq("dispatch_latency", sw_cyc - first_get_cyc, 3 * (ngets - 1) + last_lat + 1);
    check_eq("cur_valid", int'(cur_valid_o), int'(exp_valid));
    check_eq("cur_tid", int'(cur_tid_o), exp_tid);
    check_eq("cur_pri", int'(cur_pri_o), exp_pri);
    check_eq("idle", int'(idle_o), int'(exp_idle));
    $display("scan mode=%0d gets=%0d tid=%0d pri=%0d valid=%0d switch=%0d idle=%0d",
             mode, get_log.size(), cur_tid_o, cur_pri_o, cur_valid_o, sw_count - sw0, idle_o);
  endtask

  initial begin
    int alt_exp[3];
    int mode;
    bit nonempty;
    alt_exp = '{3, 5, 3};
    clear_list();

    #2 rst_ni = 1'b0;
    repeat (3) step();
    check_outputs_reset("reset");
    rst_ni = 1'b1;
    sched_en_i = 1'b1;
    step();

    // Entirely empty ready list, one tick.
    run_scan(0);

    // Task 7 alone at priority 2.
    put_task(2, 7);
    run_scan(0);

    // Tasks 3 and 5 share priority 4 and alternate on slice expiry.
    clear_list();
    put_task(4, 3);
    put_task(4, 5);
    for (int i = 0; i < 3; i++) begin
      run_scan(2);
      check_eq("alternate_tid", int'(cur_tid_o), alt_exp[i]);
    end

    // Single task 9 at priority 1: yield re-selects it without a switch.
    clear_list();
    put_task(1, 9);
    run_scan(1);
    run_scan(1);
    get_log.delete();
    for (int i = 0; i < SLICE - 1; i++) begin
      tick_i = 1'b1; step(); tick_i = 1'b0; step();
      slice_model++;
    end
    repeat (3) step();
    check_eq("slice_restart_gets", get_log.size(), 0);
    run_scan(2);

    // Ready list busy while the scheduler sits in REQ.
    run_scan(3);

    // Asynchronous reset while waiting on the ready list.
    clear_list();
    put_task(4, 3);
    force_lat = 4;
    get_log.delete();
    yield_i = 1'b1; step(); yield_i = 1'b0;
    step();
    step();
    rst_ni = 1'b0;
    #1;
    check_outputs_reset("async_reset");
    step();
    step();
    rst_ni = 1'b1;
    force_lat = 0;
    exp_valid = 1'b0; exp_tid = 0; exp_pri = 0; exp_idle = 1'b0; slice_model = 0;
    get_log.delete();
    repeat (10) step();
    check_eq("post_reset_gets", get_log.size(), 0);

    // Randomized ready-list contents and triggers.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) != 0) begin
        clear_list();
        for (int l = 0; l < NPRI; l++) begin
          if ($urandom_range(0, 1) == 1) begin
            int n;
            n = int'($urandom_range(1, 3));
            for (int k = 0; k < n; k++) put_task(l, int'($urandom_range(0, 15)));
          end
        end
      end
      if ($urandom_range(0, 5) == 0) begin
        sched_en_i = 1'b0;
        get_log.delete();
        yield_i = 1'b1; step(); yield_i = 1'b0;
        repeat (4) step();
        check_eq("disabled_gets", get_log.size(), 0);
        sched_en_i = 1'b1;
      end
      nonempty = 1'b0;
      for (int l = 0; l < NPRI; l++) if (lvl_cnt[l] > 0) nonempty = 1'b1;
      if (exp_valid) mode = (nonempty && $urandom_range(0, 1) == 1) ? 2 : 1;
      else mode = (slice_model < SLICE - 1 && $urandom_range(0, 1) == 1) ? 0 : 1;
      run_scan(mode);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
